// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift unit: operation codes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_ROTR = 2'b10,
    OP_SRA  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate; building block for serial datapaths.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    case (op_i)
      OP_SLL:  value_o = {value_i[WIDTH-2:0], 1'b0};
      OP_SRL:  value_o = {1'b0, value_i[WIDTH-1:1]};
      OP_ROTR: value_o = {value_i[0], value_i[WIDTH-1:1]};
      OP_SRA:  value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
      default: value_o = value_i;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shifter: one bit position per clock, result presented with a one-cycle done pulse.
module iterative_shift_unit
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic [WIDTH-1:0] dataIn,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             done_q;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value_i (work_q),
    .op_i    (op_q),
    .value_o (work_d)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      op_q    <= OP_SLL;
      work_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            work_q <= dataIn;
            op_q   <= op_e'(op);
            cnt_q  <= shamt;
            // A zero shift bypasses SHIFT and publishes the operand directly.
            if (shamt == '0) begin
              data_q  <= dataIn;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            data_q  <= work_d;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign dataOut = data_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed self-checking bench for iterative_shift_unit (WIDTH=32).
module tb_iterative_shift_unit;

  localparam logic [1:0] SLL  = 2'b00;
  localparam logic [1:0] SRL  = 2'b01;
  localparam logic [1:0] ROTR = 2'b10;
  localparam logic [1:0] SRA  = 2'b11;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        start;
  logic [31:0] dataIn;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_result;

  iterative_shift_unit #(.WIDTH(32)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .start   (start),
    .dataIn  (dataIn),
    .shamt   (shamt),
    .op      (op),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then follow it to its done pulse checking latency,
  // busy occupancy, result hold during the operation and the final result.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] o, input logic [31:0] exp);
    int edges;
    int busy_cyc;
    int hold_bad;
    edges    = 0;
    busy_cyc = 0;
    hold_bad = 0;
    @(negedge CLK);
    start = 1'b1; dataIn = d; shamt = s; op = o;
    @(posedge CLK);
    edges = 1;
    @(negedge CLK);
    start = 1'b0; dataIn = $urandom; shamt = 5'($urandom); op = 2'($urandom);
    while (!done && edges < 64) begin
      if (busy) busy_cyc++;
      if (dataOut !== prev_result) hold_bad++;
      @(posedge CLK);
      edges++;
      @(negedge CLK);
    end
    if (busy) busy_cyc++;
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(edges), 32'(s) + 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(s) + 32'd1);
    chk({tag, "_hold_prev"}, 32'(hold_bad), 32'd0);
    chk({tag, "_result"}, dataOut, exp);
    @(negedge CLK);
    chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    chk({tag, "_result_kept"}, dataOut, exp);
    prev_result = exp;
  endtask

  initial begin
    int edges;
    int hold_bad;
    int done_cnt;

    RSTn = 1'b0; start = 1'b1; dataIn = 32'hA5A5A5A5; shamt = 5'd3; op = SRA;
    prev_result = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_dataOut", dataOut, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    start = 1'b0;
    RSTn  = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_dataOut", dataOut, 32'h0);

    run_op("sll4",    32'h00000001, 5'd4,  SLL,  32'h00000010);
    run_op("srl31",   32'h80000000, 5'd31, SRL,  32'h00000001);
    run_op("sra31",   32'h80000000, 5'd31, SRA,  32'hFFFFFFFF);
    run_op("sra4",    32'h7FFFFFF0, 5'd4,  SRA,  32'h07FFFFFF);
    run_op("rotr4",   32'h0000000F, 5'd4,  ROTR, 32'hF0000000);
    run_op("sll_msb", 32'h80000001, 5'd1,  SLL,  32'h00000002);
    run_op("rotr31",  32'h00000001, 5'd31, ROTR, 32'h00000002);
    run_op("sra0",    32'hDEADBEEF, 5'd0,  SRA,  32'hDEADBEEF);

    // Start while busy: a pulse in SHIFT, then start held through DONE.
    @(negedge CLK);
    start = 1'b1; dataIn = 32'h00000001; shamt = 5'd8; op = SLL;
    @(posedge CLK);
    edges = 1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) begin
      @(posedge CLK); edges++; @(negedge CLK);
    end
    start = 1'b1; dataIn = 32'hFFFFFFFF; shamt = 5'd4; op = SRL;
    hold_bad = 0;
    while (!done && edges < 64) begin
      if (dataOut !== prev_result) hold_bad++;
      @(posedge CLK); edges++; @(negedge CLK);
    end
    chk("busy_start_latency", 32'(edges), 32'd9);
    chk("busy_start_hold", 32'(hold_bad), 32'd0);
    chk("busy_start_result", dataOut, 32'h00000100);
    @(negedge CLK);
    chk("held_start_idle", 32'(busy), 32'd0);
    chk("held_start_done_low", 32'(done), 32'd0);
    @(posedge CLK);
    edges = 1;
    @(negedge CLK);
    start = 1'b0;
    chk("held_start_accepted", 32'(busy), 32'd1);
    hold_bad = 0;
    while (!done && edges < 64) begin
      if (dataOut !== 32'h00000100) hold_bad++;
      @(posedge CLK); edges++; @(negedge CLK);
    end
    chk("held_start_hold_first", 32'(hold_bad), 32'd0);
    chk("held_start_latency", 32'(edges), 32'd5);
    chk("held_start_result", dataOut, 32'h0FFFFFFF);
    prev_result = 32'h0FFFFFFF;

    // Asynchronous reset in the middle of an operation.
    @(negedge CLK);
    start = 1'b1; dataIn = 32'hFFFFFFFF; shamt = 5'd20; op = SRL;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    chk("midop_busy_before", 32'(busy), 32'd1);
    #2;
    RSTn = 1'b0;
    #1;
    chk("midop_rst_busy", 32'(busy), 32'd0);
    chk("midop_rst_done", 32'(done), 32'd0);
    chk("midop_rst_dataOut", dataOut, 32'h0);
    @(negedge CLK);
    RSTn = 1'b1;
    done_cnt = 0;
    repeat (30) begin
      @(negedge CLK);
      if (done) done_cnt++;
    end
    chk("midop_no_done", 32'(done_cnt), 32'd0);
    chk("midop_idle", 32'(busy), 32'd0);
    chk("midop_dataOut_zero", dataOut, 32'h0);

    prev_result = '0;
    run_op("after_rst_srl1", 32'h00000002, 5'd1, SRL, 32'h00000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
